// File: rtl/ascon_permutation_engine.sv
// ASCON permutation engine: latches a 320-bit state, runs p12/p8/p6 with
// G_UNROLL rounds per clock, optionally XORs the key into x3/x4 at the end,
// and holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for i_start, o_ready=1
// RUN   | rounds in progress, o_busy=1
// DONE  | result held in o_state, o_valid=1
module ascon_permutation_engine #(
  parameter int G_UNROLL    = 1,
  parameter int G_KEY_WIDTH = 128
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_sys_enable,
  input  logic                   i_abort,
  input  logic                   i_start,
  input  logic [1:0]             i_mode,
  input  logic                   i_xor_key_end,
  input  logic [G_KEY_WIDTH-1:0] i_key,
  input  logic [4:0][63:0]       i_state,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_valid,
  input  logic                   i_out_ready,
  output logic [4:0][63:0]       o_state
);

  if (G_UNROLL != 1 && G_UNROLL != 2) begin : g_bad_unroll
    $error("ascon_permutation_engine: G_UNROLL must be 1 or 2");
  end
  if (G_KEY_WIDTH != 128) begin : g_bad_key
    $error("ascon_permutation_engine: G_KEY_WIDTH must be 128");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             fsm_q;
  logic [4:0][63:0]       state_q;
  logic [G_KEY_WIDTH-1:0] key_q;
  logic                   xor_key_q;
  logic [3:0]             round_q;

  logic [3:0]             start_round;
  logic [4:0][63:0]       round_state;
  logic [3:0]             round_next;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One ASCON round: constant addition, bit-sliced S-box, linear diffusion.
  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                   input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'b0, 4'hF - idx, idx};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    ascon_round[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    ascon_round[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    ascon_round[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    ascon_round[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    ascon_round[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
  endfunction

  // First round index for the requested round count (reserved mode runs p12).
  always_comb begin
    case (i_mode)
      2'b01:   start_round = 4'd4;
      2'b10:   start_round = 4'd6;
      default: start_round = 4'd0;
    endcase
  end

  // Unrolled rounds for this cycle, with the key folded in on the final step.
  always_comb begin
    round_state = state_q;
    round_next  = round_q;
    for (int u = 0; u < G_UNROLL; u++) begin
      round_state = ascon_round(round_state, round_next);
      round_next  = round_next + 4'd1;
    end
    if (round_next == 4'd12 && xor_key_q) begin
      round_state[3] = round_state[3] ^ key_q[G_KEY_WIDTH-1 -: 64];
      round_state[4] = round_state[4] ^ key_q[63:0];
    end
  end

  // Sequencer and state register; soft clear and abort both return to reset values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= ST_IDLE;
      state_q   <= '0;
      key_q     <= '0;
      xor_key_q <= 1'b0;
      round_q   <= 4'd0;
    end else if (!i_sys_enable || i_abort) begin
      fsm_q     <= ST_IDLE;
      state_q   <= '0;
      key_q     <= '0;
      xor_key_q <= 1'b0;
      round_q   <= 4'd0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q   <= i_state;
            key_q     <= i_key;
            xor_key_q <= i_xor_key_end;
            round_q   <= start_round;
            fsm_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_q <= round_state;
          round_q <= round_next;
          if (round_next == 4'd12) fsm_q <= ST_DONE;
        end
        ST_DONE: begin
          if (i_out_ready) fsm_q <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (fsm_q == ST_IDLE);
  assign o_busy  = (fsm_q == ST_RUN);
  assign o_valid = (fsm_q == ST_DONE);
  assign o_state = state_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Bench for ascon_permutation_engine: two instances (1 and 2 rounds/clock)
// share one stimulus stream and are checked every cycle against a
// table-driven reference permutation.
module tb_ascon_permutation_engine;

  typedef logic [4:0][63:0] st_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         sys_enable = 1'b0;
  logic         abort = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         xk = 1'b0;
  logic [127:0] key = '0;
  st_t          state_in = '0;
  logic         out_ready = 1'b0;

  logic ready [2];
  logic busy  [2];
  logic valid [2];
  st_t  ost   [2];

  int checks = 0;
  int passed = 0;

  st_t          m_st  [2];
  int           m_r   [2];
  int           m_ph  [2];
  logic [127:0] m_key [2];
  logic         m_xk  [2];

  always #5 clock = ~clock;

  ascon_permutation_engine #(.G_UNROLL(1), .G_KEY_WIDTH(128)) dut_u1 (
    .clock(clock), .reset_n(reset_n), .i_sys_enable(sys_enable), .i_abort(abort),
    .i_start(start), .i_mode(mode), .i_xor_key_end(xk), .i_key(key),
    .i_state(state_in), .o_ready(ready[0]), .o_busy(busy[0]), .o_valid(valid[0]),
    .i_out_ready(out_ready), .o_state(ost[0])
  );

  ascon_permutation_engine #(.G_UNROLL(2), .G_KEY_WIDTH(128)) dut_u2 (
    .clock(clock), .reset_n(reset_n), .i_sys_enable(sys_enable), .i_abort(abort),
    .i_start(start), .i_mode(mode), .i_xor_key_end(xk), .i_key(key),
    .i_state(state_in), .o_ready(ready[1]), .o_busy(busy[1]), .o_valid(valid[1]),
    .i_out_ready(out_ready), .o_state(ost[1])
  );

  function automatic logic [4:0] sbox5(input logic [4:0] v);
    logic [4:0] tbl [32];
    tbl = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
            5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
            5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
            5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    return tbl[v];
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [7:0] rc(input int i);
    return 8'(((15 - i) << 4) | i);
  endfunction

  function automatic st_t ref_round(input st_t s, input int i);
    st_t t;
    logic [4:0] col, o;
    t = s;
    t[2] = t[2] ^ {56'b0, rc(i)};
    for (int b = 0; b < 64; b++) begin
      col = {t[0][b], t[1][b], t[2][b], t[3][b], t[4][b]};
      o = sbox5(col);
      t[0][b] = o[4];
      t[1][b] = o[3];
      t[2][b] = o[2];
      t[3][b] = o[1];
      t[4][b] = o[0];
    end
    t[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
    t[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
    t[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
    t[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
    t[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
    return t;
  endfunction

  function automatic st_t ref_perm(input st_t s, input int nr);
    st_t t;
    t = s;
    for (int i = 12 - nr; i < 12; i++) t = ref_round(t, i);
    return t;
  endfunction

  function automatic int nr_of(input logic [1:0] m);
    case (m)
      2'b01:   return 8;
      2'b10:   return 6;
      default: return 12;
    endcase
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s got=%h want=%h", name, act, exp);
  endtask

  // Reference model advances on each clock edge, then both instances are compared.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n || !sys_enable || abort) begin
        m_ph[k] = 0; m_st[k] = '0; m_r[k] = 0; m_key[k] = '0; m_xk[k] = 1'b0;
      end else begin
        case (m_ph[k])
          0: if (start) begin
               m_st[k] = state_in; m_key[k] = key; m_xk[k] = xk;
               m_r[k] = 12 - nr_of(mode); m_ph[k] = 1;
             end
          1: begin
               for (int u = 0; u < k + 1; u++) begin
                 m_st[k] = ref_round(m_st[k], m_r[k]);
                 m_r[k]++;
               end
               if (m_r[k] >= 12) begin
                 if (m_xk[k]) begin
                   m_st[k][3] = m_st[k][3] ^ m_key[k][127:64];
                   m_st[k][4] = m_st[k][4] ^ m_key[k][63:0];
                 end
                 m_ph[k] = 2;
               end
             end
          default: if (out_ready) m_ph[k] = 0;
        endcase
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ready[k] === (m_ph[k] == 0) && busy[k] === (m_ph[k] == 1) &&
          valid[k] === (m_ph[k] == 2) && ost[k] === m_st[k])
        passed++;
      else
        $display("FAIL cycle_u%0d t=%0t rdy/bsy/vld=%b%b%b want=%b%b%b state=%h want=%h",
                 k + 1, $time, ready[k], busy[k], valid[k],
                 m_ph[k] == 0, m_ph[k] == 1, m_ph[k] == 2, ost[k], m_st[k]);
    end
  end

  // Issue one start, scramble inputs afterwards, collect both results and latencies.
  // With hold>0 a start is pulsed during RUN and again while DONE is back-pressured.
  task automatic run_txn(input logic [1:0] m, input logic x, input logic [127:0] kk,
                         input st_t s, input int hold,
                         output st_t r0, output st_t r1, output int l0, output int l1);
    int k;
    r0 = 'x; r1 = 'x;
    mode = m; xk = x; key = kk; state_in = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0; mode = ~m; key = ~kk; state_in = ~s;
    l0 = -1; l1 = -1; k = 0;
    while ((l0 < 0 || l1 < 0) && k < 40) begin
      if (valid[0] && l0 < 0) begin l0 = k; r0 = ost[0]; end
      if (valid[1] && l1 < 0) begin l1 = k; r1 = ost[1]; end
      start = (hold > 0 && k == 1);
      @(negedge clock);
      start = 1'b0;
      k++;
    end
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      @(negedge clock);
      start = 1'b0;
      chk("bp_valid", 320'(valid[0]), 320'(1'b1));
      chk("bp_state", ost[0], r0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("idle_after_take_u1", 320'(ready[0]), 320'(1'b1));
    chk("idle_after_take_u2", 320'(ready[1]), 320'(1'b1));
  endtask

  initial begin
    st_t r0, r1, p12z, s8;
    int l0, l1, k;
    logic [127:0] kseq;

    chk("pin_sbox_00", 320'(sbox5(5'd0)), 320'(5'h04));
    chk("pin_sbox_01", 320'(sbox5(5'd1)), 320'(5'h0b));
    chk("pin_sbox_1f", 320'(sbox5(5'd31)), 320'(5'h17));
    chk("pin_rc_0", 320'(rc(0)), 320'(8'hF0));
    chk("pin_rc_4", 320'(rc(4)), 320'(8'hB4));
    chk("pin_rc_6", 320'(rc(6)), 320'(8'h96));
    chk("pin_ror", 320'(ror(64'h1, 1)), 320'(64'h8000000000000000));

    repeat (3) @(negedge clock);
    reset_n = 1'b1; sys_enable = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", 320'(ready[i]), 320'(1'b1));
      chk("reset_busy",  320'(busy[i]),  320'(1'b0));
      chk("reset_valid", 320'(valid[i]), 320'(1'b0));
      chk("reset_state", ost[i], '0);
    end

    p12z = ref_perm('0, 12);
    run_txn(2'b00, 1'b0, '0, '0, 0, r0, r1, l0, l1);
    chk("p12_lat_u1", 320'(l0), 320'(12));
    chk("p12_lat_u2", 320'(l1), 320'(6));
    chk("p12_zero_u1", r0, p12z);
    chk("p12_unroll_equal", r1, r0);

    s8 = '0; s8[0] = 64'h80400C0600000000;
    run_txn(2'b01, 1'b0, '0, s8, 0, r0, r1, l0, l1);
    chk("p8_lat_u1", 320'(l0), 320'(8));
    chk("p8_lat_u2", 320'(l1), 320'(4));
    chk("p8_u1", r0, ref_perm(s8, 8));
    chk("p8_u2", r1, ref_perm(s8, 8));

    run_txn(2'b10, 1'b0, '0, s8, 0, r0, r1, l0, l1);
    chk("p6_lat_u1", 320'(l0), 320'(6));
    chk("p6_lat_u2", 320'(l1), 320'(3));
    chk("p6_u1", r0, ref_perm(s8, 6));
    chk("p6_u2", r1, ref_perm(s8, 6));

    run_txn(2'b11, 1'b0, '0, s8, 0, r0, r1, l0, l1);
    chk("p12_reserved_lat", 320'(l0), 320'(12));
    chk("p12_reserved", r0, ref_perm(s8, 12));

    kseq = 128'h000102030405060708090A0B0C0D0E0F;
    run_txn(2'b00, 1'b1, kseq, '0, 0, r0, r1, l0, l1);
    chk("key_x0_x2", 320'({r0[2], r0[1], r0[0]}), 320'({p12z[2], p12z[1], p12z[0]}));
    chk("key_x3", 320'(r0[3]), 320'(p12z[3] ^ kseq[127:64]));
    chk("key_x4", 320'(r0[4]), 320'(p12z[4] ^ kseq[63:0]));
    chk("key_u2", r1, r0);

    run_txn(2'b00, 1'b0, '0, s8, 5, r0, r1, l0, l1);
    chk("bp_result", r0, ref_perm(s8, 12));
    repeat (3) @(negedge clock);
    chk("no_second_busy", 320'(busy[0]), 320'(1'b0));
    chk("no_second_valid", 320'(valid[0]), 320'(1'b0));

    mode = 2'b00; xk = 1'b0; state_in = s8; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", 320'(busy[0]), 320'(1'b0));
    chk("abort_ready", 320'(ready[0]), 320'(1'b1));
    chk("abort_state", ost[0], '0);

    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (!valid[0] && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("pre_clear_valid", 320'(valid[0]), 320'(1'b1));
    sys_enable = 1'b0;
    @(negedge clock);
    sys_enable = 1'b1;
    chk("clear_ready", 320'(ready[0]), 320'(1'b1));
    chk("clear_valid", 320'(valid[0]), 320'(1'b0));
    chk("clear_state", ost[0], '0);
    chk("clear_state_u2", ost[1], '0);

    run_txn(2'b01, 1'b0, '0, s8, 0, r0, r1, l0, l1);
    chk("post_abort_lat", 320'(l0), 320'(8));
    chk("post_abort_result", r0, ref_perm(s8, 8));
    chk("post_abort_u2", r1, ref_perm(s8, 8));

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ascon_permutation_engine.md
Name: ascon_permutation_engine

Overview:
- Self-sequencing ASCON permutation core: accepts a 320-bit state, runs p12/p8/p6 internally and returns the permuted state over a valid/ready handshake.
- Generalises the single-round externally-sequenced permutation datapath:
  - owns the round counter and FSM;
  - applies G_UNROLL rounds per clock;
  - offers an optional post-permutation key XOR for finalization.
- Sits between the ASCON mode controller (absorb/squeeze sequencing) and the state/data registers.

Parameters:
- G_UNROLL, 1, rounds computed per clock. Legal values: 1, 2. Any other value is an elaboration error.
- G_KEY_WIDTH, 128, key width XORed into x3/x4 at the end. Legal values: 128 only.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- i_sys_enable  in  1  high = operate; low = synchronous soft clear
- i_abort  in  1  synchronous abort to IDLE
- i_start  in  1  request permutation, accepted when o_ready=1
- i_mode  in  2  rounds: 00=12, 01=8, 10=6, 11=12 (reserved)
- i_xor_key_end  in  1  XOR key into {x3,x4} of the final result
- i_key  in  128  key; sampled at start acceptance
- i_state  in  t_state_array (5x64)  input state x0..x4; sampled at start acceptance
- o_ready  out  1  engine idle, can accept i_start
- o_busy  out  1  rounds in progress
- o_valid  out  1  o_state holds the finished result
- i_out_ready  in  1  consumer accepts the result
- o_state  out  t_state_array  result state (state register)

Behaviour:
- Reset: reset_n is asynchronous, active-low; the clock is clock.
  - FSM=IDLE, state reg=0, key reg=0, round counter=0.
  - o_valid=0, o_busy=0, o_ready=1, o_state=0.
- Priority (highest first): reset_n, i_sys_enable=0, i_abort, FSM action.
  - i_sys_enable=0 or i_abort=1 at an edge gives the reset values above at the next edge, regardless of FSM state.
- FSM states: IDLE, RUN, DONE.
  - o_ready = (IDLE), o_busy = (RUN), o_valid = (DONE); all from registered state.
- IDLE:
  - On i_start=1: latch i_state, i_key, i_xor_key_end and nr from i_mode.
  - Round index r = 12-nr (0, 4 or 6). Go to RUN.
  - i_start with i_mode=11 runs 12 rounds.
- RUN, each cycle:
  - Apply G_UNROLL consecutive rounds (indices r, r+1 when U=2) combinationally on the state reg; register the result.
  - r += G_UNROLL.
  - When the new r reaches 12: apply the key XOR if latched (x3 ^= key[127:64], x4 ^= key[63:0]) to the registered value, then go to DONE.
- One round, for round index i:
  - x2 ^= {56'b0, (4'hF-i), i[3:0]}.
  - 5-bit ASCON S-box bit-sliced across 64 columns.
  - Linear diffusion:
    - x0 ^= ror19 ^ ror28
    - x1 ^= ror61 ^ ror39
    - x2 ^= ror1 ^ ror6
    - x3 ^= ror10 ^ ror17
    - x4 ^= ror7 ^ ror41
- Latency: with start accepted at edge E, o_valid=1 after edge E+nr/G_UNROLL.
  - G_UNROLL=1: 12/8/6 cycles. G_UNROLL=2: 6/4/3 cycles.
- DONE:
  - o_state is stable while o_valid=1 and i_out_ready=0.
  - On i_out_ready=1: go to IDLE; o_ready=1 the next cycle. o_state keeps its value in IDLE until the next start.
- i_start outside IDLE is ignored; there is no queuing. Back-to-back minimum period is nr/U+2 cycles.
- i_state and i_key changes after acceptance have no effect.
- i_out_ready outside DONE is ignored.
- Abort mid-RUN: o_busy=0 and state reg=0 the next cycle; no o_valid pulse.

Test Plan:
- Reset, then release, with i_start=0 -> o_ready=1, o_valid=0, o_busy=0, o_state all-zero.
- p12 on all-zero state, G_UNROLL=1 and 2:
  - Start at edge E -> o_busy for 12 (resp. 6) cycles.
  - o_valid at E+12 (resp. E+6).
  - o_state equals the golden C model p12(0), identical for both unrolls.
- i_mode=01 then 10 with state x0=64'h80400C0600000000, x1..x4=0:
  - Valid after 8 and 6 cycles (U=1).
  - Result matches golden p8 and p6, with first round constants 0xB4 and 0x96.
- i_xor_key_end=1, key=128'h000102...0F, p12 -> x3,x4 equal golden p12 output XOR key; x0..x2 unaffected.
- Backpressure: hold i_out_ready=0 for 5 cycles in DONE -> o_valid and o_state stable.
  - Then i_out_ready=1 -> IDLE next edge.
  - i_start pulsed during RUN/DONE is ignored (no second result).
- i_abort asserted on cycle 3 of RUN, then i_sys_enable=0 during DONE -> next cycle IDLE, o_state=0, no o_valid.
  - A subsequent start produces a correct result.
